apb_dma_cfg_slave: RTL and testbench

Synthesizable APB completer holding the DMA engine's configuration and status registers. It sits between the APB interconnect (driven by the FPGA APB master) and the DMA datapath. It supplies source/destination address, length and a start pulse, and collects busy/done status into a sticky flag and an interrupt. It supports a parameterizable number of wait states and reports errors via PSLVERR.

---
 rtl/apb_dma_cfg_slave.sv | 218 +++++++++++++++++++++
 tb/tb_apb_dma_cfg_slave.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_dma_cfg_slave.sv
// APB completer for the DMA engine's configuration/status registers.
// Latches each APB setup, optionally inserts wait states, then responds and commits in RESP.
module apb_dma_cfg_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PSTRB_WIDTH = 4,
  parameter int PPROT_WIDTH = 3,
  parameter int LEN_WIDTH   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [ADDR_WIDTH-1:0]  s_apb_paddr,
  input  logic                   s_apb_psel,
  input  logic                   s_apb_penable,
  input  logic                   s_apb_pwrite,
  input  logic [DATA_WIDTH-1:0]  s_apb_pwdata,
  input  logic [PSTRB_WIDTH-1:0] s_apb_pstrb,
  input  logic [PPROT_WIDTH-1:0] s_apb_pprot,
  output logic [DATA_WIDTH-1:0]  s_apb_prdata,
  output logic                   s_apb_pready,
  output logic                   s_apb_pslverr,
  output logic [31:0]            dma_src_addr,
  output logic [31:0]            dma_dst_addr,
  output logic [LEN_WIDTH-1:0]   dma_len,
  output logic                   dma_start,
  input  logic                   dma_busy,
  input  logic                   dma_done,
  output logic                   irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [2:0] IDX_SRC    = 3'd0;
  localparam logic [2:0] IDX_DST    = 3'd1;
  localparam logic [2:0] IDX_LEN    = 3'd2;
  localparam logic [2:0] IDX_CMD    = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;
  localparam logic [2:0] IDX_IRQEN  = 3'd5;
  localparam logic [3:0] WS         = 4'(WAIT_STATES);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [4:0]             addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [PSTRB_WIDTH-1:0] strb_q, strb_d;
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   irq_en_q, irq_en_d;
  logic                   done_q, done_d;
  logic                   irq_q, irq_d;
  logic                   start_q, start_d;

  logic                   accept;
  logic                   commit;
  logic                   err;
  logic                   start_req;
  logic                   done_clr;
  logic [31:0]            rdata;
  logic [31:0]            len_wr;
  logic                   unused_inputs;

  assign unused_inputs = ^{s_apb_pprot, s_apb_paddr[ADDR_WIDTH-1:5]};

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return res;
  endfunction

  // Decode of the latched transfer; err also gates the commit.
  always_comb begin
    rdata     = '0;
    err       = 1'b0;
    start_req = write_q && (addr_q[4:2] == IDX_CMD) && (addr_q[1:0] == 2'b00) &&
                strb_q[0] && wdata_q[0];
    if (addr_q[1:0] != 2'b00) begin
      err = 1'b1;
    end else begin
      case (addr_q[4:2])
        IDX_SRC:    rdata = src_q;
        IDX_DST:    rdata = dst_q;
        IDX_LEN:    rdata = 32'(len_q);
        IDX_CMD:    rdata = '0;
        IDX_STATUS: rdata = {30'b0, done_q, dma_busy};
        IDX_IRQEN:  rdata = {31'b0, irq_en_q};
        default:    err   = 1'b1;
      endcase
    end
    if (start_req && (dma_busy || (len_q == '0)))
      err = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      start_q  <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = s_apb_psel && !s_apb_penable &&
              ((state_q == ST_IDLE) || (state_q == ST_RESP));
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
      ST_WAIT: begin
        if (!s_apb_psel) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1)
            state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer capture and register commit on the edge that ends RESP.
  always_comb begin
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    commit   = (state_q == ST_RESP) && !err;
    done_clr = 1'b0;
    len_wr   = apply_strb(32'(len_q), wdata_q, strb_q);
    if (accept) begin
      addr_d  = s_apb_paddr[4:0];
      write_d = s_apb_pwrite;
      wdata_d = s_apb_pwdata;
      strb_d  = s_apb_pstrb;
    end
    if (commit && write_q) begin
      case (addr_q[4:2])
        IDX_SRC:    src_d = apply_strb(src_q, wdata_q, strb_q);
        IDX_DST:    dst_d = apply_strb(dst_q, wdata_q, strb_q);
        IDX_LEN:    len_d = len_wr[LEN_WIDTH-1:0];
        IDX_STATUS: done_clr = strb_q[0] && wdata_q[1];
        IDX_IRQEN:  if (strb_q[0]) irq_en_d = wdata_q[0];
        default: ;
      endcase
    end
    start_d = commit && start_req;
    done_d  = dma_done || (done_q && !done_clr);
    irq_d   = irq_en_q && done_q;
  end

  always_comb begin
    s_apb_pready  = (state_q == ST_RESP);
    s_apb_pslverr = s_apb_pready && err;
    s_apb_prdata  = (s_apb_pready && !write_q && !err) ? rdata : '0;
  end

  assign dma_src_addr = src_q;
  assign dma_dst_addr = dst_q;
  assign dma_len      = len_q;
  assign dma_start    = start_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_apb_dma_cfg_slave.sv
// Directed bench for apb_dma_cfg_slave with zero and three wait states.
// Expected responses are queued as each transfer is driven and popped when PREADY appears.
module tb_apb_dma_cfg_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] paddr;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        dma_busy, dma_done;

  logic [31:0] prdata0, prdata3, src0, src3, dst0, dst3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [15:0] len0, len3;
  logic        start0, start3, irq0, irq3;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  apb_dma_cfg_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .resetn(resetn), .s_apb_paddr(paddr), .s_apb_psel(psel0),
    .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
    .s_apb_pstrb(pstrb), .s_apb_pprot(pprot), .s_apb_prdata(prdata0),
    .s_apb_pready(pready0), .s_apb_pslverr(pslverr0), .dma_src_addr(src0),
    .dma_dst_addr(dst0), .dma_len(len0), .dma_start(start0),
    .dma_busy(dma_busy), .dma_done(dma_done), .irq(irq0));

  apb_dma_cfg_slave #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .resetn(resetn), .s_apb_paddr(paddr), .s_apb_psel(psel3),
    .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
    .s_apb_pstrb(pstrb), .s_apb_pprot(pprot), .s_apb_prdata(prdata3),
    .s_apb_pready(pready3), .s_apb_pslverr(pslverr3), .dma_src_addr(src3),
    .dma_dst_addr(dst3), .dma_len(len3), .dma_start(start3),
    .dma_busy(dma_busy), .dma_done(dma_done), .irq(irq3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_pready(input bit ws3);
    return ws3 ? pready3 : pready0;
  endfunction

  function automatic logic get_pslverr(input bit ws3);
    return ws3 ? pslverr3 : pslverr0;
  endfunction

  function automatic logic [31:0] get_prdata(input bit ws3);
    return ws3 ? prdata3 : prdata0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full APB transfer; returns #1 after the commit edge.
  task automatic xfer(input bit ws3, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] st,
                      input logic [31:0] ed, input bit ee, input bit done_pulse);
    logic [32:0] e;
    int n;
    sb.push_back({ee, ed});
    psel0 = !ws3; psel3 = ws3; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = st;
    tick();
    penable = 1'b1;
    n = 1;
    while (get_pready(ws3) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("pready_latency", n, ws3 ? 4 : 1);
    if (get_pready(ws3) === 1'b1) begin
      e = sb.pop_front();
      chk("prdata", get_prdata(ws3), e[31:0]);
      chk("pslverr", {31'b0, get_pslverr(ws3)}, {31'b0, e[32]});
    end
    if (done_pulse) dma_done = 1'b1;
    tick();
    dma_done = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st, input bit ee);
    xfer(1'b0, 1'b1, a, d, st, 32'h0, ee, 1'b0);
  endtask

  task automatic rd0(input logic [31:0] a, input logic [31:0] ed, input bit ee);
    xfer(1'b0, 1'b0, a, 32'h0, 4'hF, ed, ee, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; paddr = '0; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0;
    pwdata = '0; pstrb = '0; pprot = 3'b010; dma_busy = 0; dma_done = 0;
    repeat (3) tick();
    chk("rst_pready", {31'b0, pready0}, 32'h0);
    chk("rst_prdata", prdata0, 32'h0);
    chk("rst_start_irq", {30'b0, start0, irq0}, 32'h0);
    resetn = 1'b1;
    tick();

    // Reset values of every offset, then unmapped offsets.
    for (int i = 0; i < 6; i++) rd0(32'(i * 4), 32'h0, 1'b0);
    chk("irq_after_reset", {31'b0, irq0}, 32'h0);
    rd0(32'h18, 32'h0, 1'b1);
    rd0(32'h1C, 32'h0, 1'b1);

    // Basic register writes and readback.
    wr0(32'h00, 32'h1000_0000, 4'hF, 1'b0);
    wr0(32'h04, 32'h2000_0040, 4'hF, 1'b0);
    wr0(32'h08, 32'hABCD_0100, 4'hF, 1'b0);
    rd0(32'h00, 32'h1000_0000, 1'b0);
    rd0(32'h04, 32'h2000_0040, 1'b0);
    rd0(32'h08, 32'h0000_0100, 1'b0);
    chk("dma_len", {16'h0, len0}, 32'h0000_0100);
    chk("dma_dst", dst0, 32'h2000_0040);
    rd0(32'hFFFF_FFE0, 32'h1000_0000, 1'b0);

    // Byte strobes and misaligned access.
    wr0(32'h00, 32'h0, 4'hF, 1'b0);
    wr0(32'h00, 32'hFFFF_FFFF, 4'b0101, 1'b0);
    rd0(32'h00, 32'h00FF_00FF, 1'b0);
    wr0(32'h02, 32'h1234_5678, 4'hF, 1'b1);
    rd0(32'h00, 32'h00FF_00FF, 1'b0);
    wr0(32'h00, 32'h1234_5678, 4'h0, 1'b0);
    chk("src_after_nostrb", src0, 32'h00FF_00FF);

    // Start pulse and its error cases.
    chk("start_idle", {31'b0, start0}, 32'h0);
    wr0(32'h0C, 32'h1, 4'hF, 1'b0);
    chk("start_pulse", {31'b0, start0}, 32'h1);
    chk("len_during_start", {16'h0, len0}, 32'h0000_0100);
    tick();
    chk("start_single", {31'b0, start0}, 32'h0);
    dma_busy = 1'b1;
    rd0(32'h10, 32'h1, 1'b0);
    wr0(32'h0C, 32'h1, 4'hF, 1'b1);
    chk("start_busy_none", {31'b0, start0}, 32'h0);
    dma_busy = 1'b0;
    wr0(32'h08, 32'h0, 4'hF, 1'b0);
    wr0(32'h0C, 32'h1, 4'hF, 1'b1);
    chk("start_len0_none", {31'b0, start0}, 32'h0);
    rd0(32'h0C, 32'h0, 1'b0);

    // Sticky done, interrupt and write-1-to-clear.
    wr0(32'h14, 32'h1, 4'hF, 1'b0);
    rd0(32'h14, 32'h1, 1'b0);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("irq_lag", {31'b0, irq0}, 32'h0);
    tick();
    chk("irq_set", {31'b0, irq0}, 32'h1);
    rd0(32'h10, 32'h2, 1'b0);
    xfer(1'b0, 1'b1, 32'h10, 32'h2, 4'hF, 32'h0, 1'b0, 1'b1);
    rd0(32'h10, 32'h2, 1'b0);
    wr0(32'h10, 32'h3, 4'hF, 1'b0);
    chk("irq_hold_after_clr", {31'b0, irq0}, 32'h1);
    tick();
    chk("irq_clear", {31'b0, irq0}, 32'h0);
    rd0(32'h10, 32'h0, 1'b0);

    // Three wait states.
    xfer(1'b1, 1'b1, 32'h04, 32'hABCD_0004, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, 32'hABCD_0004, 1'b0, 1'b0);
    xfer(1'b1, 1'b0, 32'h18, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0);

    // Abandon a transfer in WAIT by dropping psel.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00;
    pwdata = 32'h0000_0055; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    chk("abandon_no_pready", {31'b0, pready3}, 32'h0);
    psel3 = 1'b0; penable = 1'b0;
    repeat (4) tick();
    chk("abandon_still_low", {31'b0, pready3}, 32'h0);
    chk("abandon_src", src3, 32'h0);
    xfer(1'b1, 1'b0, 32'h00, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
    tick();
    penable = 1'b1;
    tick();
    resetn = 1'b0;
    #1;
    chk("rst_wait_pready", {31'b0, pready3}, 32'h0);
    chk("rst_wait_dst", dst3, 32'h0);
    chk("rst_src0", src0, 32'h0);
    chk("rst_irq_en_flag", {30'b0, irq0, start3}, 32'h0);
    psel3 = 1'b0; penable = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    chk("scoreboard_empty", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
